// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and helpers for the cache-to-memory responder
package mem_ctrl_pkg;

    localparam int BLOCK_ADDR_W = 16;
    localparam int BLOCK_DATA_W = 64;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
    typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0] block_data_t;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_ctrl_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_ctrl_main_mem_array.sv
// rtl/mem_ctrl_main_mem_array.sv - single-port block memory, synchronous write, combinational read
module mem_ctrl_main_mem_array
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  main_mem_block_addr_t addr,
    input  block_data_t          wdata,
    output block_data_t          rdata
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    block_data_t               mem [DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] idx;

    // Upper address bits alias onto the same block.
    assign idx = addr[MEM_DEPTH_LOG2-1:0];

    generate
        if (MEM_DEPTH_LOG2 < BLOCK_ADDR_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[BLOCK_ADDR_W-1:MEM_DEPTH_LOG2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - icache/dcache memory responder; MEM_CTRL_STATS_EN adds access counters
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY    = 4,
    parameter int MEM_DEPTH_LOG2 = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 icache_req_valid,
    input  req_type_t            icache_req_type,
    input  main_mem_block_addr_t icache_req_block_addr,
    output logic                 icache_req_ready,
    output logic                 icache_resp_valid,
    output block_data_t          icache_resp_block_data,
    input  logic                 dcache_req_valid,
    input  req_type_t            dcache_req_type,
    input  main_mem_block_addr_t dcache_req_block_addr,
    input  block_data_t          dcache_req_block_data,
    output logic                 dcache_req_ready,
    output logic                 dcache_resp_valid,
    output block_data_t          dcache_resp_block_data
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_icache_reads,
    output logic [31:0]          stat_dcache_reads,
    output logic [31:0]          stat_dcache_writes,
    output logic [31:0]          stat_conflict_cycles
`endif
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    mem_ctrl_state_t      state, state_nxt;
    logic                 sel, sel_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 i_pending, d_pending;
    main_mem_block_addr_t i_addr, d_addr;
    req_type_t            d_type;
    block_data_t          d_data;
    logic                 i_accept, d_accept, i_clear, d_clear, i_avail, d_avail;
    logic                 done, mem_we, unused_icache_type;
    main_mem_block_addr_t mem_addr;
    block_data_t          mem_rdata, resp_data, i_resp_data, d_resp_data;

    // The icache only ever reads, so its request type carries no information.
    assign unused_icache_type = icache_req_type;

    assign icache_req_ready = ~rst & ~i_pending;
    assign dcache_req_ready = ~rst & ~d_pending;
    assign i_accept         = icache_req_valid & icache_req_ready;
    assign d_accept         = dcache_req_valid & dcache_req_ready;
    assign i_clear          = (state == RESP) & ~sel;
    assign d_clear          = (state == RESP) & sel;
    assign i_avail          = i_pending & ~i_clear;
    assign d_avail          = d_pending & ~d_clear;
    assign done             = (state == BUSY) & (cnt == '0);
    assign mem_addr         = sel ? d_addr : i_addr;
    assign mem_we           = ~rst & done & sel & (d_type == WRITE);
    assign resp_data        = (sel & (d_type == WRITE)) ? d_data : mem_rdata;

    mem_ctrl_main_mem_array #(.MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (d_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            i_pending <= 1'b0;
            d_pending <= 1'b0;
        end else begin
            if (i_accept)     i_pending <= 1'b1;
            else if (i_clear) i_pending <= 1'b0;
            if (d_accept)     d_pending <= 1'b1;
            else if (d_clear) d_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_accept) begin
            i_addr <= icache_req_block_addr;
        end
        if (d_accept) begin
            d_type <= dcache_req_type;
            d_addr <= dcache_req_block_addr;
            d_data <= dcache_req_block_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RESP arbitrates like IDLE but ignores the slot it is retiring this cycle.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (i_avail) begin
                    sel_nxt   = 1'b0;
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end else if (d_avail) begin
                    sel_nxt   = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_resp_data <= '0;
            d_resp_data <= '0;
        end else if (done) begin
            if (sel) d_resp_data <= resp_data;
            else     i_resp_data <= resp_data;
        end
    end

    assign icache_resp_valid      = ~rst & i_clear;
    assign dcache_resp_valid      = ~rst & d_clear;
    assign icache_resp_block_data = rst ? '0 : i_resp_data;
    assign dcache_resp_block_data = rst ? '0 : d_resp_data;

`ifdef MEM_CTRL_STATS_EN
    logic conflict;

    // A slot waiting while the other port owns the memory.
    assign conflict = (state != IDLE) & ((i_pending & sel) | (d_pending & ~sel));

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_icache_reads    <= '0;
            stat_dcache_reads    <= '0;
            stat_dcache_writes   <= '0;
            stat_conflict_cycles <= '0;
        end else begin
            if (i_clear)                       stat_icache_reads  <= sat_inc(stat_icache_reads);
            if (d_clear && (d_type == READ))   stat_dcache_reads  <= sat_inc(stat_dcache_reads);
            if (d_clear && (d_type == WRITE))  stat_dcache_writes <= sat_inc(stat_dcache_writes);
            if (conflict)                      stat_conflict_cycles <= sat_inc(stat_conflict_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl; MEM_CTRL_STATS_EN enables the counter checks
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int L = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 icache_req_valid = 1'b0;
    req_type_t            icache_req_type = READ;
    main_mem_block_addr_t icache_req_block_addr = '0;
    logic                 icache_req_ready;
    logic                 icache_resp_valid;
    block_data_t          icache_resp_block_data;
    logic                 dcache_req_valid = 1'b0;
    req_type_t            dcache_req_type = READ;
    main_mem_block_addr_t dcache_req_block_addr = '0;
    block_data_t          dcache_req_block_data = '0;
    logic                 dcache_req_ready;
    logic                 dcache_resp_valid;
    block_data_t          dcache_resp_block_data;
`ifdef MEM_CTRL_STATS_EN
    logic [31:0] stat_icache_reads, stat_dcache_reads, stat_dcache_writes, stat_conflict_cycles;
`endif

    mem_ctrl #(.MEM_LATENCY(L), .MEM_DEPTH_LOG2(12)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .icache_req_valid       (icache_req_valid),
        .icache_req_type        (icache_req_type),
        .icache_req_block_addr  (icache_req_block_addr),
        .icache_req_ready       (icache_req_ready),
        .icache_resp_valid      (icache_resp_valid),
        .icache_resp_block_data (icache_resp_block_data),
        .dcache_req_valid       (dcache_req_valid),
        .dcache_req_type        (dcache_req_type),
        .dcache_req_block_addr  (dcache_req_block_addr),
        .dcache_req_block_data  (dcache_req_block_data),
        .dcache_req_ready       (dcache_req_ready),
        .dcache_resp_valid      (dcache_resp_valid),
        .dcache_resp_block_data (dcache_resp_block_data)
`ifdef MEM_CTRL_STATS_EN
        ,
        .stat_icache_reads      (stat_icache_reads),
        .stat_dcache_reads      (stat_dcache_reads),
        .stat_dcache_writes     (stat_dcache_writes),
        .stat_conflict_cycles   (stat_conflict_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        block_data_t data;
        int          due;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    block_data_t model [main_mem_block_addr_t];

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (icache_resp_valid) begin
                if (iq.size() == 0) begin
                    check("i_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = iq.pop_front();
                    check("i_resp_data", icache_resp_block_data, e.data);
                    check("i_resp_cycle", 64'(cyc), 64'(e.due));
                    check("i_resp_excl", 64'(dcache_resp_valid), 64'd0);
                end
            end
            if (dcache_resp_valid) begin
                if (dq.size() == 0) begin
                    check("d_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = dq.pop_front();
                    check("d_resp_data", dcache_resp_block_data, e.data);
                    check("d_resp_cycle", 64'(cyc), 64'(e.due));
                    check("d_resp_excl", 64'(icache_resp_valid), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic i_issue(input main_mem_block_addr_t a, input int due_off);
        exp_t e;
        check("i_ready_pre", 64'(icache_req_ready), 64'd1);
        icache_req_valid      = 1'b1;
        icache_req_type       = READ;
        icache_req_block_addr = a;
        e.data = model[a];
        e.due  = cyc + due_off;
        iq.push_back(e);
    endtask

    task automatic d_issue(input logic wr, input main_mem_block_addr_t a, input block_data_t wd,
                           input int due_off, input bit track);
        exp_t e;
        check("d_ready_pre", 64'(dcache_req_ready), 64'd1);
        dcache_req_valid      = 1'b1;
        dcache_req_type       = wr ? WRITE : READ;
        dcache_req_block_addr = a;
        dcache_req_block_data = wd;
        if (track) begin
            if (wr) model[a] = wd;
            e.data = wr ? wd : model[a];
            e.due  = cyc + due_off;
            dq.push_back(e);
        end
    endtask

    task automatic release_reqs();
        tick();
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((iq.size() != 0 || dq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 64'(n < 200), 64'd1);
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_ready", 64'(icache_req_ready), 64'd0);
        check("rst_d_ready", 64'(dcache_req_ready), 64'd0);
        check("rst_i_valid", 64'(icache_resp_valid), 64'd0);
        check("rst_d_valid", 64'(dcache_resp_valid), 64'd0);
        check("rst_i_data", icache_resp_block_data, 64'd0);
        check("rst_d_data", dcache_resp_block_data, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_i_ready", 64'(icache_req_ready), 64'd1);
        check("post_rst_d_ready", 64'(dcache_req_ready), 64'd1);
        tick();

        // preload 0x10 then icache read with ready/latency checks
        d_issue(1'b1, 16'h0010, 64'hDEAD_BEEF_CAFE_F00D, L + 2, 1'b1);
        release_reqs();
        drain();
        i_issue(16'h0010, L + 2);
        release_reqs();
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            check("i_ready_busy", 64'(icache_req_ready), 64'd0);
        end
        @(negedge clk);
        check("i_ready_back", 64'(icache_req_ready), 64'd1);
        drain();

        // write then read back
        d_issue(1'b1, 16'h0022, 64'h1122_3344_5566_7788, L + 2, 1'b1);
        release_reqs();
        drain();
        i_issue(16'h0022, L + 2);
        release_reqs();
        drain();

        // simultaneous requests
        d_issue(1'b1, 16'h0001, 64'hA1A1_0000_0000_0001, L + 2, 1'b1);
        release_reqs();
        drain();
        d_issue(1'b1, 16'h0002, 64'hB2B2_0000_0000_0002, L + 2, 1'b1);
        release_reqs();
        drain();
        i_issue(16'h0001, L + 2);
        d_issue(1'b0, 16'h0002, 64'd0, 2 * L + 3, 1'b1);
        release_reqs();
        drain();

        // dcache arrives mid-access; served back-to-back from RESP
        i_issue(16'h0010, L + 2);
        release_reqs();
        tick();
        check("i_ready_inflight", 64'(icache_req_ready), 64'd0);
        d_issue(1'b0, 16'h0022, 64'd0, 2 * L + 1, 1'b1);
        release_reqs();
        drain();

        for (int i = 0; i < 4; i++) begin
            main_mem_block_addr_t a;
            block_data_t          d;
            a = 16'h0100 + 16'(i * 37);
            d = {$urandom, $urandom};
            d_issue(1'b1, a, d, L + 2, 1'b1);
            release_reqs();
            drain();
            i_issue(a, L + 2);
            release_reqs();
            drain();
        end

        // reset during BUSY of a dcache write
        d_issue(1'b1, 16'h0030, 64'h0303_0303_0303_0303, L + 2, 1'b1);
        release_reqs();
        drain();
        d_issue(1'b1, 16'h0030, 64'hBAD0_BAD0_BAD0_BAD0, 0, 1'b0);
        release_reqs();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_i_ready", 64'(icache_req_ready), 64'd0);
        check("midrst_d_ready", 64'(dcache_req_ready), 64'd0);
        check("midrst_d_valid", 64'(dcache_resp_valid), 64'd0);
        check("midrst_d_data", dcache_resp_block_data, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_i_ready", 64'(icache_req_ready), 64'd1);
        check("after_rst_d_ready", 64'(dcache_req_ready), 64'd1);
        repeat (12) tick();
        i_issue(16'h0030, L + 2);
        release_reqs();
        drain();

`ifdef MEM_CTRL_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            i_issue(16'h0010, L + 2);
            release_reqs();
            drain();
        end
        for (int i = 0; i < 2; i++) begin
            d_issue(1'b1, 16'h0040 + 16'(i), 64'h4040_0000_0000_0000 + 64'(i), L + 2, 1'b1);
            release_reqs();
            drain();
        end
        check("stat_icache_reads", 64'(stat_icache_reads), 64'd3);
        check("stat_dcache_writes", 64'(stat_dcache_writes), 64'd2);
        check("stat_dcache_reads", 64'(stat_dcache_reads), 64'd0);
        check("stat_conflict_cycles", 64'(stat_conflict_cycles), 64'd0);
`endif

        check("i_queue_empty", 64'(iq.size()), 64'd0);
        check("d_queue_empty", 64'(dq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the cache-to-memory request/response interface.
- Accepts block requests from the icache and the dcache, with the icache winning arbitration.
- Serves each request from an internal behavioral main-memory block array after a fixed latency.
- Returns a single-cycle, latency-sensitive response pulse to the requesting cache.
- Sits between the two cache instances and main memory, and is the only owner of main-memory state.

Parameters:
- MEM_LATENCY, 4: number of BUSY cycles per access; legal values are 1 and above.
- MEM_DEPTH_LOG2, 12: log2 of the number of blocks held in the main-memory array.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- icache_req_valid  in  1  icache request valid
- icache_req_type  in  req_type_t  READ/WRITE; the icache only issues READ
- icache_req_block_addr  in  main_mem_block_addr_t  block address
- icache_req_ready  out  1  icache request slot free
- icache_resp_valid  out  1  one-cycle response pulse
- icache_resp_block_data  out  block_data_t  response block
- dcache_req_valid  in  1  dcache request valid
- dcache_req_type  in  req_type_t  READ or WRITE (write-through)
- dcache_req_block_addr  in  main_mem_block_addr_t  block address
- dcache_req_block_data  in  block_data_t  write data, used only for WRITE
- dcache_req_ready  out  1  dcache request slot free
- dcache_resp_valid  out  1  one-cycle response pulse
- dcache_resp_block_data  out  block_data_t  response block

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Request slots: each port has a one-entry slot holding pending, type, addr and data.
  - port_req_ready = ~port_pending.
  - A request is accepted when valid & ready are high at a clock edge; pending is set at that edge.
  - An icache request is always accepted, because the icache has at most one outstanding request and its slot is free whenever it is valid.
- Memory array: indexed by block_addr[MEM_DEPTH_LOG2-1:0]; upper address bits are ignored. The array is not reset.
- FSM states: IDLE, BUSY, RESP. A 'sel' register records the granted port: 0 = icache, 1 = dcache.
- IDLE:
  - If icache_pending: sel=0, go to BUSY.
  - Else if dcache_pending: sel=1, go to BUSY.
  - The counter is loaded with MEM_LATENCY-1 on either grant.
  - A request accepted in a given cycle is first granted in the following cycle.
- BUSY:
  - Decrement the counter.
  - When the counter is 0: capture the response data and, for WRITE, write the slot data into the array; then go to RESP.
  - For READ, the response data is the array contents. For WRITE, the response data is the written data.
- RESP:
  - Assert sel_port_resp_valid=1 with the captured data for exactly one cycle; the other port's resp_valid stays 0.
  - Clear the selected slot's pending at the end of the cycle.
  - Then arbitrate exactly as in IDLE. If the other slot is pending, go directly to BUSY; otherwise go to IDLE.
- Latency:
  - An uncontended access accepted in cycle 0 responds in cycle MEM_LATENCY+2.
  - ready is high again in cycle MEM_LATENCY+3.
- Simultaneous requests: icache is served first, then dcache. The dcache response is delayed by an additional MEM_LATENCY+1 cycles.
- Ordering: accesses to the same block are serialized in grant order; a read granted after a write returns the new data.
- Write response: WRITE also produces a response pulse; the dcache uses it to clear its waiting state.
- Reset behaviour:
  - All outputs are 0 during and after reset: resp_valid=0 and resp_block_data=0 on both ports, and both ready outputs are 0 while rst is asserted.
  - FSM goes to IDLE, pending is cleared, and the counter is 0.
  - Reset mid-operation drops the in-flight request with no response and no array write if still in BUSY. The ready outputs return to 1 in the first cycle after rst deasserts.
- resp_block_data: holds its last value when resp_valid=0.

Optional Feature:
- MEM_CTRL_STATS_EN defined: adds four 32-bit saturating counters, exposed as output ports: stat_icache_reads, stat_dcache_reads, stat_dcache_writes, stat_conflict_cycles.
  - The read/write counters increment in RESP according to type and sel.
  - stat_conflict_cycles increments on every cycle in which one slot is pending but not being served.
  - All counters clear on rst.
- MEM_CTRL_STATS_EN not defined: the counter ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- global_defs.svh:
  - Existing typedefs: req_type_t, main_mem_block_addr_t, block_data_t.
  - New: mem_ctrl_state_t enum {IDLE, BUSY, RESP}.
- Sub-module main_mem_array: a single-port behavioral block memory with synchronous write and combinational read, parameterized by MEM_DEPTH_LOG2. It holds no reset state.

Test Plan:
- Preload block 0x10 with 0xDEADBEEF_CAFEF00D; icache READ 0x10 in cycle 0 -> icache_resp_valid=1 only in cycle 6 (MEM_LATENCY=4) with that data; icache_req_ready low in cycles 1-6.
- dcache WRITE 0x22 with data 0x1122334455667788 -> dcache_resp_valid pulse in cycle 6 carrying the written data; a following icache READ 0x22 returns 0x1122334455667788.
- icache READ 0x01 and dcache READ 0x02 in the same cycle -> icache responds in cycle 6, dcache in cycle 11; each resp_valid is exactly one cycle and the other stays 0.
- dcache request held during an in-flight icache access -> the dcache request is accepted while its slot is free and served back-to-back directly from RESP to BUSY, without an IDLE cycle.
- Assert rst in cycle 3 of a dcache WRITE to 0x30 -> no resp_valid ever; block 0x30 is unchanged; ready=1 in the first cycle after rst deasserts.
- MEM_CTRL_STATS_EN defined: run 3 icache reads and 2 dcache writes -> stat_icache_reads=3, stat_dcache_writes=2, stat_dcache_reads=0.
